// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, read-arbiter state encoding
// and a width helper for index fields.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      RD_IDLE  = 3'd0,
      RD_ADDR  = 3'd1,
      RD_DATA  = 3'd2,
      RD_ERR   = 3'd3,
      RD_DRAIN = 3'd4
   } rd_arb_state_e;

   // $clog2 that never returns 0, so a one-bit field still exists for n<=2.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping to 0.
// Purely combinational so it can be shared by read and write arbiters.
module rr_pick
   import axi4lite_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = clog2_min1(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Two passes: indices >= ptr first, then the wrapped indices below ptr.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!any_o && req_i[j] && (IW'(j) >= ptr_i)) begin
            grant_o[j] = 1'b1;
            idx_o      = IW'(j);
            any_o      = 1'b1;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!any_o && req_i[j] && (IW'(j) < ptr_i)) begin
            grant_o[j] = 1'b1;
            idx_o      = IW'(j);
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4lite_rd_arbiter_rr.sv
// N-master AXI4-Lite read arbiter with round-robin grant, registered AR
// stage and a response timeout that answers SLVERR and drains the late beat.
//
// Handshakes: a beat moves on a channel only in a cycle where valid and
// ready are both high; valid, once raised, keeps its payload stable until
// that cycle. One transaction is outstanding at a time.
module axi4lite_rd_arbiter_rr
   import axi4lite_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = clog2_min1(NUM_MASTERS),
   parameter int TIMEOUT     = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_arvalid,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
   output logic [NUM_MASTERS-1:0]            m_arready,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
   output logic [NUM_MASTERS*2-1:0]          m_rresp,
   input  logic [NUM_MASTERS-1:0]            m_rready,
   output logic                              s_arvalid,
   output logic [ID_WIDTH-1:0]               s_arid,
   output logic [ADDR_WIDTH-1:0]             s_araddr,
   input  logic                              s_arready,
   input  logic                              s_rvalid,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   input  logic [1:0]                        s_rresp,
   output logic                              s_rready,
   output logic [2:0]                        dbg_state_o
);

   // Timer holds 0..TIMEOUT; it saturates rather than wrapping.
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

   rd_arb_state_e           state_q;
   logic [ID_WIDTH-1:0]     rr_ptr_q;
   logic [ID_WIDTH-1:0]     rr_ptr_d;
   logic [ID_WIDTH-1:0]     grant_idx_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [TW-1:0]           timer_q;

   logic [NUM_MASTERS-1:0]  pick_grant;
   logic [ID_WIDTH-1:0]     pick_idx;
   logic                    pick_any;
   logic [ADDR_WIDTH-1:0]   pick_addr;
   logic                    gnt_rready;

   rr_pick #(
      .N  (NUM_MASTERS),
      .IW (ID_WIDTH)
   ) u_pick (
      .req_i   (m_arvalid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // Next pointer: one past the master just served, wrapping at NUM_MASTERS.
   assign rr_ptr_d = (grant_idx_q == ID_WIDTH'(NUM_MASTERS - 1)) ? '0
                                                                 : grant_idx_q + 1'b1;

   assign dbg_state_o = state_q;

   // Mux out the picked master's address and the granted master's rready.
   always_comb begin
      pick_addr  = '0;
      gnt_rready = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_idx == ID_WIDTH'(i)) begin
            pick_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
         if (grant_idx_q == ID_WIDTH'(i)) begin
            gnt_rready = m_rready[i];
         end
      end
   end

   // Arbiter FSM: grant, forward AR, wait for R (with timeout), drain late beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RD_IDLE;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         addr_q      <= '0;
         timer_q     <= '0;
      end else begin
         case (state_q)
            RD_IDLE: begin
               if (pick_any) begin
                  grant_idx_q <= pick_idx;
                  addr_q      <= pick_addr;
                  state_q     <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (s_arready) begin
                  timer_q <= '0;
                  state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (s_rvalid && gnt_rready) begin
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= RD_IDLE;
               end else if (TIMEOUT != 0) begin
                  // A beat arriving in the expiry cycle wins over the timeout.
                  if (!s_rvalid && (timer_q == TMO_LAST)) begin
                     state_q <= RD_ERR;
                  end else if (timer_q != TMO_MAX) begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end
            RD_ERR: begin
               if (gnt_rready) begin
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               if (s_rvalid) begin
                  state_q <= RD_IDLE;
               end
            end
            default: state_q <= RD_IDLE;
         endcase
      end
   end

   // Channel outputs decoded from state; everything is forced to 0 in reset.
   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      s_arvalid = 1'b0;
      s_arid    = '0;
      s_araddr  = '0;
      s_rready  = 1'b0;
      if (!rst) begin
         case (state_q)
            RD_IDLE: begin
               m_arready = pick_grant;
            end
            RD_ADDR: begin
               s_arvalid = 1'b1;
               s_arid    = grant_idx_q;
               s_araddr  = addr_q;
            end
            RD_DATA: begin
               for (int i = 0; i < NUM_MASTERS; i++) begin
                  if (grant_idx_q == ID_WIDTH'(i)) begin
                     m_rvalid[i]                       = s_rvalid;
                     m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                     m_rresp[i*2 +: 2]                 = s_rresp;
                  end
               end
               s_rready = gnt_rready;
            end
            RD_ERR: begin
               for (int i = 0; i < NUM_MASTERS; i++) begin
                  if (grant_idx_q == ID_WIDTH'(i)) begin
                     m_rvalid[i]       = 1'b1;
                     m_rresp[i*2 +: 2] = RESP_SLVERR;
                  end
               end
            end
            RD_DRAIN: begin
               s_rready = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
